// File: rtl/fec_adc_framer_pkg.sv
// Shared widths, frame type and FSM encodings for the ADC framer.
// Frame width is derived so message_data_t always matches MSG_W.
package encoder_fec_pkg;
  localparam int SAMPLE_W        = 12;
  localparam int SAMPLES_PER_MSG = 4;
  localparam int MSG_W           = SAMPLE_W * SAMPLES_PER_MSG;
  localparam int TIMEOUT_CYC     = 256;
  localparam int FILL_CNT_W      = (SAMPLES_PER_MSG > 1) ? $clog2(SAMPLES_PER_MSG) : 1;
  localparam int TMO_W           = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [MSG_W-1:0]    message_data_t;

  typedef enum logic [1:0] {FILL_EMPTY, FILL_FILLING, FILL_HOLD} fill_state_t;
  typedef enum logic       {OUT_IDLE, OUT_REQ} out_state_t;
endpackage

// File: rtl/fec_adc_framer_if.sv
// Sample input and frame req/ack handshake of the ADC framer.
// slave = framer side, master = sample source / frame consumer side.
interface fec_adc_framer_if;
  import encoder_fec_pkg::*;

  logic          sample_valid;
  sample_t       sample_data;
  logic          req;
  logic          ack;
  message_data_t data_out;

  modport slave (input sample_valid, sample_data, ack, output req, data_out);
  modport master (output sample_valid, sample_data, ack, input req, data_out);
endinterface

// File: rtl/fec_sample_packer.sv
// Fill buffer, slot counter and fill FSM; optional idle flush when
// FEC_FRAMER_FLUSH_TIMEOUT_EN is defined.
// state        | meaning
// FILL_EMPTY   | no samples in the fill buffer
// FILL_FILLING | partial frame being collected
// FILL_HOLD    | complete frame waiting for the output register
module fec_sample_packer
  import encoder_fec_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sample_valid,
  input  sample_t       sample_data,
  input  logic          out_free,
  output logic          load,
  output message_data_t frame,
  output logic          drop
);
  localparam logic [FILL_CNT_W-1:0] LAST_SLOT = FILL_CNT_W'(SAMPLES_PER_MSG - 1);

  fill_state_t             state_q, state_d;
  message_data_t           fill_q, fill_d;
  logic [FILL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    accept, complete, timeout_hit;

  assign accept = en && sample_valid && (state_q != FILL_HOLD);
  assign drop   = en && sample_valid && (state_q == FILL_HOLD);

`ifdef FEC_FRAMER_FLUSH_TIMEOUT_EN
  logic [TMO_W-1:0] idle_q;
  logic             idle_run;

  assign idle_run    = en && !accept && (cnt_q != '0);
  assign timeout_hit = idle_run && (idle_q == '0);

  // Down-counter: the TIMEOUT_CYC-th consecutive idle edge hits terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        idle_q <= TMO_W'(TIMEOUT_CYC - 1);
    else if (accept || timeout_hit) idle_q <= TMO_W'(TIMEOUT_CYC - 1);
    else if (idle_run)              idle_q <= idle_q - 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL_EMPTY;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    frame    = fill_q;
    if (accept) fill_d[int'(cnt_q)*SAMPLE_W +: SAMPLE_W] = sample_data;
    complete = (accept && (cnt_q == LAST_SLOT)) || timeout_hit;
    case (state_q)
      FILL_EMPTY, FILL_FILLING: begin
        if (complete) begin
          frame = fill_d;
          cnt_d = '0;
          if (out_free) begin
            load    = 1'b1;
            fill_d  = '0;  // cleared so a flushed partial frame has zero padding
            state_d = FILL_EMPTY;
          end else begin
            state_d = FILL_HOLD;
          end
        end else if (accept) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = FILL_FILLING;
        end
      end
      FILL_HOLD: begin
        if (out_free) begin
          load    = 1'b1;
          fill_d  = '0;
          state_d = FILL_EMPTY;
        end
      end
      default: state_d = FILL_EMPTY;
    endcase
  end
endmodule

// File: rtl/fec_adc_framer.sv
// ADC framer top: output frame register, req/ack FSM and drop statistics.
// Optional idle flush enabled by defining FEC_FRAMER_FLUSH_TIMEOUT_EN.
// state    | meaning
// OUT_IDLE | no frame presented
// OUT_REQ  | data_out holds a frame awaiting ack
module fec_adc_framer
  import encoder_fec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  fec_adc_framer_if.slave        bus,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  out_state_t    out_q, out_d;
  message_data_t data_q;
  message_data_t frame;
  logic          out_free, load, drop;

  assign bus.req      = (out_q == OUT_REQ);
  assign bus.data_out = data_q;
  assign out_free     = !bus.req || bus.ack;

  fec_sample_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_valid (bus.sample_valid),
    .sample_data  (bus.sample_data),
    .out_free     (out_free),
    .load         (load),
    .frame        (frame),
    .drop         (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= OUT_IDLE;
    else     out_q <= out_d;
  end

  // A load on the ack edge keeps req high for back-to-back frames.
  always_comb begin
    out_d = out_q;
    case (out_q)
      OUT_IDLE: if (load) out_d = OUT_REQ;
      OUT_REQ:  if (bus.ack && !load) out_d = OUT_IDLE;
      default:  out_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (load) data_q <= frame;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
endmodule
